// File: rtl/id_decode_pkg.sv
// Shared decode definitions for the ID and EX stages: opcodes, field positions, register-file geometry.
// Pure definitions, no latency or backpressure of its own.
package id_decode_pkg;

    localparam int NREG   = 8;
    localparam int REG_AW = 3;
    localparam int DATA_W = 8;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 0;
    localparam int OFF_MSB = 5;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MOV = 2'b10,
        OP_JMP = 2'b11
    } op_e;

    function automatic logic [DATA_W-1:0] sext_off(input logic [OFF_MSB:0] off);
        return {{(DATA_W-OFF_MSB-1){off[OFF_MSB]}}, off};
    endfunction

endpackage

// File: rtl/id_decode_regfile.sv
// Register array, two combinational read ports with same-cycle write-back bypass, one write port.
// Reads are zero-latency, write lands on the next rising edge; no backpressure.
// Asynchronous reset clears every register.
module regfile
    import id_decode_pkg::*;
#(
    parameter int NREG = id_decode_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] ra_addr,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_dat,
    output logic [DATA_W-1:0] rb_dat
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Write-back data wins over the stored value so the consumer never sees a stale operand.
    always_comb begin
        ra_dat = regs[ra_addr];
        rb_dat = regs[rb_addr];
        if (wb_en && (wb_addr == ra_addr)) ra_dat = wb_data;
        if (wb_en && (wb_addr == rb_addr)) rb_dat = wb_data;
    end

endmodule

// File: rtl/id_decode.sv
// Instruction decode stage: field decode, relative jump resolution, one-slot squash, ID/EX register.
// One cycle IF/ID to ID/EX; jump target and PCsrc are combinational. No backpressure.
// A taken jump squashes the following slot; reset overrides jumps and write-back.
module id_decode
    import id_decode_pkg::*;
#(
    parameter int NREG = id_decode_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        inst_code,
    input  logic [7:0]        PCline,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [7:0]        PC_j,
    output logic              PCsrc,
    output logic              ex_valid,
    output logic [1:0]        ex_op,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic              ex_we
);

    op_e               op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [DATA_W-1:0] rd_dat;
    logic [DATA_W-1:0] rs_dat;
    logic              squash;
    logic              take_jmp;
    logic              alu_ok;

    assign op = op_e'(inst_code[OP_MSB:OP_LSB]);
    assign rd = inst_code[RD_MSB:RD_LSB];
    assign rs = inst_code[RS_MSB:RS_LSB];

    assign PC_j     = PCline + sext_off(inst_code[OFF_MSB:0]);
    assign take_jmp = (op == OP_JMP) && !squash && !reset;
    assign PCsrc    = !take_jmp;
    assign alu_ok   = (op != OP_JMP) && !squash;

    regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .ra_addr (rd),
        .rb_addr (rs),
        .ra_dat  (rd_dat),
        .rb_dat  (rs_dat)
    );

    // Squash lasts exactly one slot: while set, take_jmp is low so it clears on the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash   <= 1'b0;
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_op    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
        end else begin
            squash   <= take_jmp;
            ex_valid <= alu_ok;
            ex_we    <= alu_ok;
            ex_op    <= op;
            ex_rd    <= rd;
            ex_a     <= rd_dat;
            ex_b     <= rs_dat;
        end
    end

endmodule

// File: doc/id_decode.md
ID_DECODE -- requirements
Module: id_decode

Interface
REQ-001 SHALL have parameter NREG, default 8, number of 8-bit general registers (register address width 3).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port inst_code  input  8  instruction from the IF/ID register.
REQ-005 SHALL have port PCline  input  8  PC+1 of that instruction from the IF/ID register.
REQ-006 SHALL have ports wb_en  input  1, wb_addr  input  3, wb_data  input  8  register write-back from the later stage.
REQ-007 SHALL have port PC_j  output  8  jump target returned to instruction fetch.
REQ-008 SHALL have port PCsrc  output  1  1 = fetch continues sequentially, 0 = fetch loads PC_j.
REQ-009 SHALL have ports ex_valid  output  1, ex_op  output  2, ex_rd  output  3, ex_a  output  8, ex_b  output  8, ex_we  output  1  registered ID/EX outputs.

Function
REQ-010 SHALL decode inst_code as op=[7:6], rd=[5:3], rs=[2:0]; op 00 ADD rd,rs; 01 SUB rd,rs; 10 MOV rd,rs; 11 JMP with signed 6-bit offset [5:0].
REQ-011 SHALL drive PC_j combinationally as PCline + sign-extend(inst_code[5:0]), modulo 256 (wrap-around, carry discarded).
REQ-012 SHALL drive PCsrc combinationally 0 when op==11 and the current slot is not squashed, else 1.
REQ-013 SHALL set a one-bit squash flag on each rising edge where PCsrc==0, and clear it on the next edge; while set, the IF/ID instruction is treated as a bubble (no jump, ex_valid=0).
REQ-014 SHALL on each rising edge load ex_op=op, ex_rd=rd, ex_a=R[rd], ex_b=R[rs] (operands after bypass, REQ-016).
REQ-015 SHALL set ex_valid=1 and ex_we=1 for ADD/SUB/MOV not squashed; ex_valid=0 and ex_we=0 for JMP or squashed slots (one-cycle latency IF/ID to ID/EX).
REQ-016 SHALL bypass: when wb_en=1 and wb_addr equals rd or rs in the same cycle, the corresponding operand is wb_data, not the stored value.
REQ-017 SHALL write wb_data into R[wb_addr] on the rising edge when wb_en=1; all registers including R0 writable.
REQ-018 SHALL treat back-to-back JMPs: the second JMP, arriving in the squashed slot, is ignored.
REQ-019 SHALL give reset priority over a simultaneous write-back or jump.

Reset
REQ-020 SHALL on reset assertion immediately clear all registers R0..R7 to 0x00, squash flag to 0, ex_valid, ex_we, ex_op, ex_rd, ex_a, ex_b to 0.
REQ-021 SHALL with reset asserted and inst_code=0x00 present PCsrc=1, PC_j=PCline.
REQ-022 SHALL resume normal decode on the first rising edge after reset deasserts; reset mid-jump cancels any pending squash.

Structure
REQ-023 SHALL place opcode constants (ADD, SUB, MOV, JMP), NREG and field bit positions in a shared package used also by the execute stage.
REQ-024 SHALL implement the register array with two combinational read ports, one write port and bypass as a sub-module named regfile; decode, jump logic, squash flag and ID/EX register live in id_decode.

Verification
REQ-025 SHALL check reset: assert reset mid-cycle with R3 written to 0x55 -> R3 reads 0x00, ex_valid=0, PCsrc=1 immediately.
REQ-026 SHALL check ALU decode: write R1=0x12, R2=0x34, then inst 0x0A (ADD r1,r2) -> next edge ex_valid=1, ex_op=00, ex_rd=1, ex_a=0x12, ex_b=0x34, ex_we=1.
REQ-027 SHALL check jump: PCline=0x10, inst 0xC5 -> PC_j=0x15, PCsrc=0; next cycle PCsrc=1, ex_valid=0; inst 0xFE at PCline=0x10 -> PC_j=0x0E.
REQ-028 SHALL check wrap: PCline=0xFE, inst 0xDF (offset +31) -> PC_j=0x1D.
REQ-029 SHALL check bypass: wb_en=1, wb_addr=2, wb_data=0x99 same cycle as inst 0x0A -> ex_b=0x99.
REQ-030 SHALL check back-to-back JMP: 0xC3 then 0xC7 -> PCsrc=0 only for the first, second produces ex_valid=0 and PCsrc=1.
